adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one pipelined fast adder (WIDTH bits, fixed latency WIDTH/8 cycles, no stall, no reset) between NUM_REQ requesters.
- Grants at most one request per cycle, round-robin, into an issue register that drives the adder operands.
- Carries a requester tag alongside each in-flight operation and returns the sum, carry-out and tag when the adder result emerges.
- Sits between the requesting units and the adder instance; the adder itself is instantiated outside this block.

Parameters:
- WIDTH, 32, operand width; multiple of 8; must match the adder instance.
- NUM_REQ, 4, number of requesters; 2..16.
- LATENCY, WIDTH/8, adder latency in cycles from operand-valid at a posedge to result-valid; must equal the adder's.
- ID_W, $clog2(NUM_REQ), requester tag width (localparam).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester grant; one-hot or zero
- req_a_i  in  NUM_REQ*WIDTH  packed A operands; requester k at [k*WIDTH +: WIDTH]
- req_b_i  in  NUM_REQ*WIDTH  packed B operands
- req_cin_i  in  NUM_REQ  per-requester carry-in
- add_a_o  out  WIDTH  to adder a_i
- add_b_o  out  WIDTH  to adder b_i
- add_cin_o  out  1  to adder cin_i
- add_sum_i  in  WIDTH  from adder out_o
- add_cout_i  in  1  from adder cout_o
- rsp_valid_o  out  1  result valid; single-cycle pulse per operation
- rsp_id_o  out  ID_W  requester tag of result
- rsp_sum_o  out  WIDTH  sum
- rsp_cout_o  out  1  carry-out
- busy_o  out  1  any operation in the issue register or in flight

Behaviour:
- Handshake
  - A transfer occurs on req_valid_i[k] & req_ready_o[k] at a posedge.
  - req_ready_o is combinational from req_valid_i and the RR pointer: exactly one bit is set when any valid is high.
  - No backpressure exists on the adder or on rsp_*; the requester must sink every rsp_valid_o pulse.
- Arbitration
  - Round-robin pointer ptr (ID_W bits) marks the last granted requester.
  - Search starts at ptr+1 and wraps modulo NUM_REQ.
  - On a grant to k, ptr <= k. ptr is unchanged when nothing is granted.
  - Reset value of ptr is NUM_REQ-1, so requester 0 has first priority.
- Issue stage
  - On a grant, register the granted A, B and cin into add_a_o, add_b_o and add_cin_o, and set iss_valid=1, iss_id=k.
  - Otherwise clear iss_valid and hold the operand registers.
- Tag pipeline
  - A LATENCY-deep shift register of {valid, id} is loaded from {iss_valid, iss_id} every cycle.
  - rsp_valid_o is the last stage's valid and rsp_id_o is the last stage's id.
  - rsp_sum_o and rsp_cout_o pass add_sum_i and add_cout_i through combinationally.
- Latency
  - A request accepted at posedge T gives rsp_valid_o=1 during cycle T+1+LATENCY.
  - Sustained throughput is one operation per cycle.
  - Results return in acceptance order.
- busy_o = iss_valid | OR of all tag-pipeline valids.
- Reset
  - ptr=NUM_REQ-1.
  - iss_valid=0, all tag valids=0.
  - add_a_o=0, add_b_o=0, add_cin_o=0.
  - rsp_valid_o=0, rsp_id_o=0, busy_o=0.
  - req_ready_o=0 while rst_i=1.
- Reset mid-operation: all in-flight tags are discarded. Adder outputs emerging after reset produce no rsp_valid_o. No stale result is delivered.
- Arithmetic: {rsp_cout_o, rsp_sum_o} = A + B + cin, modulo 2^(WIDTH+1); the adder computes it, and this block does not recompute it.
- Simultaneous events: a new grant and a result emerging in the same cycle are independent. All requesters valid gives a strict rotation 0,1,2,...,NUM_REQ-1,0.

Decomposition:
- Package adder_ctrl_pkg holds:
  - the default WIDTH and NUM_REQ constants;
  - function clog2;
  - typedef rsp_t {logic valid; logic [ID_W-1:0] id;}.
- Sub-module tag_pipe holds the parameterised LATENCY-deep valid/id shift register with synchronous reset of the valids only.
- The arbiter and issue register remain in adder_arbiter.

Test Plan:
- Reset, then req 2 with A=0x0000_0005, B=0x0000_0003, cin=1 at T -> rsp_valid_o at T+5 (WIDTH=32, LATENCY=4), id=2, sum=0x0000_0009, cout=0.
- Carry chain: A=0xFFFF_FFFF, B=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1.
- All four requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; eight consecutive rsp pulses with ids in that order and correct sums.
- Requesters 1 and 3 valid, then 1 drops -> grants alternate 1,3,1,3, then 3 every cycle; ptr wraps correctly.
- Issue 3 back-to-back ops, assert rst_i for 1 cycle two cycles later -> no rsp_valid_o afterwards; busy_o=0 the cycle after reset; the next request returns normally.
- Idle gaps: requests at T, T+3 and T+4 -> responses at T+5, T+8 and T+9 with no spurious pulses between them.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared constants, helpers and types for the adder request arbiter.
// Imported by the arbiter top and available to any unit that talks to it.
package adder_ctrl_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int NUM_REQ_DEF = 4;

    // Ceiling log2 usable in constant expressions; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int ID_W_DEF = clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
    } rsp_t;

endpackage

// File: rtl/tag_pipe.sv
// Shift register carrying {valid, id} alongside the external adder pipeline.
// Only the valid bits are reset; ids are don't-care while their valid is low.
module tag_pipe #(
    parameter int LATENCY = 4,
    parameter int ID_W    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    input  logic [ID_W-1:0] in_id_i,
    output logic            out_valid_o,
    output logic [ID_W-1:0] out_id_o,
    output logic            any_valid_o
);

    logic [LATENCY-1:0]           valid_q, valid_d;
    logic [LATENCY-1:0][ID_W-1:0] id_q, id_d;

    // Next-state: shift every stage one step toward the output.
    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        valid_d[0] = in_valid_i;
        id_d[0]    = in_id_i;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    // Valid stages, cleared by reset so no stale result is ever reported.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag stages, free-running.
    always_ff @(posedge clk_i) begin
        id_q <= id_d;
    end

    assign out_valid_o = valid_q[LATENCY-1];
    // Gate the id with valid so the tag output reads zero whenever idle.
    assign out_id_o    = valid_q[LATENCY-1] ? id_q[LATENCY-1] : '0;
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external pipelined adder between NUM_REQ
// requesters; returns sum, carry-out and requester tag when the result emerges.
module adder_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int  WIDTH   = WIDTH_DEF,
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  LATENCY = WIDTH / 8,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_cin_i,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    output logic                     add_cin_o,
    input  logic [WIDTH-1:0]         add_sum_i,
    input  logic                     add_cout_i,
    output logic                     rsp_valid_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_sum_o,
    output logic                     rsp_cout_o,
    output logic                     busy_o
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               iss_valid_q, iss_valid_d;
    logic [ID_W-1:0]    iss_id_q, iss_id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;

    logic [NUM_REQ-1:0] grant_s;
    logic               gnt_any_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic [ID_W-1:0]    cand_s;
    logic               tag_busy_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_s   = '0;
        gnt_any_s = 1'b0;
        gnt_idx_s = ptr_q;
        cand_s    = ptr_q;
        if (!rst_i) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                cand_s = ID_W'((int'(ptr_q) + i) % NUM_REQ);
                if (!gnt_any_s && req_valid_i[cand_s]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = cand_s;
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
            grant_s[gnt_idx_s] = gnt_any_s;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready_o = grant_s;

    // Issue-register next state: capture the granted operands, else hold.
    always_comb begin
        ptr_d       = ptr_q;
        iss_valid_d = gnt_any_s;
        iss_id_d    = iss_id_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        if (gnt_any_s) begin
            ptr_d    = gnt_idx_s;
            iss_id_d = gnt_idx_s;
            a_d      = req_a_i[int'(gnt_idx_s)*WIDTH +: WIDTH];
            b_d      = req_b_i[int'(gnt_idx_s)*WIDTH +: WIDTH];
            cin_d    = req_cin_i[gnt_idx_s];
        end else begin
            ptr_d    = ptr_q;
        end
    end

    // Pointer and issue register; reset gives requester 0 first priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
        end
    end

    assign add_a_o   = a_q;
    assign add_b_o   = b_q;
    assign add_cin_o = cin_q;

    tag_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) u_tag_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (iss_valid_q),
        .in_id_i     (iss_id_q),
        .out_valid_o (rsp_valid_o),
        .out_id_o    (rsp_id_o),
        .any_valid_o (tag_busy_s)
    );

    // The adder owns the arithmetic; results are forwarded untouched.
    assign rsp_sum_o  = add_sum_i;
    assign rsp_cout_o = add_cout_i;
    assign busy_o     = iss_valid_q | tag_busy_s;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural adder and a
// scoreboard of expected responses indexed by the cycle they are due.
module tb_adder_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int LATENCY = WIDTH / 8;
    localparam int ID_W    = 2;
    localparam int RING    = 64;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_a_i;
    logic [NUM_REQ*WIDTH-1:0] req_b_i;
    logic [NUM_REQ-1:0]       req_cin_i;
    logic [WIDTH-1:0]         add_a_o, add_b_o, add_sum_i, rsp_sum_o;
    logic                     add_cin_o, add_cout_i, rsp_valid_o, rsp_cout_o, busy_o;
    logic [ID_W-1:0]          rsp_id_o;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_cin_i(req_cin_i),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
        .add_sum_i(add_sum_i), .add_cout_i(add_cout_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_sum_o(rsp_sum_o), .rsp_cout_o(rsp_cout_o), .busy_o(busy_o)
    );

    // Behavioural pipelined adder: no reset, no stall, fixed latency.
    logic [WIDTH:0] add_pipe [LATENCY];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a_o} + {1'b0, add_b_o} + {{WIDTH{1'b0}}, add_cin_o};
        for (int i = 1; i < LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum_i  = add_pipe[LATENCY-1][WIDTH-1:0];
    assign add_cout_i = add_pipe[LATENCY-1][WIDTH];

    // Reference model state.
    int              cyc = 0;
    int              m_ptr = NUM_REQ - 1;
    logic            slot_v   [RING];
    logic [ID_W-1:0] slot_id  [RING];
    logic [WIDTH:0]  slot_res [RING];
    int              checks = 0;
    int              errors = 0;

    function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int p);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_ready();
        logic [NUM_REQ-1:0] r;
        int g;
        r = '0;
        g = model_grant(req_valid_i, m_ptr);
        if (!rst_i && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int d = 0; d <= LATENCY; d++) b = b | slot_v[(cyc + d) % RING];
        return b;
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a_i[k*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            req_b_i[k*WIDTH +: WIDTH] = $urandom();
            req_cin_i[k]              = 1'($urandom_range(0, 1));
        end
    endtask

    // Advance one clock, update the model from what the DUT sampled, return at negedge.
    task automatic tick();
        int g;
        int s;
        @(posedge clk);
        cyc++;
        s = (cyc + LATENCY) % RING;
        if (rst_i) begin
            for (int i = 0; i < RING; i++) slot_v[i] = 1'b0;
            m_ptr = NUM_REQ - 1;
        end else begin
            g = model_grant(req_valid_i, m_ptr);
            slot_v[s] = (g >= 0);
            if (g >= 0) begin
                slot_id[s]  = g[ID_W-1:0];
                slot_res[s] = {1'b0, req_a_i[g*WIDTH +: WIDTH]} + {1'b0, req_b_i[g*WIDTH +: WIDTH]}
                            + {{WIDTH{1'b0}}, req_cin_i[g]};
                m_ptr = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = '1;
        rand_ops();
        #1;
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready_o);
        end
        tick();
        tick();
        req_valid_i = '0;
        rst_i = 1'b0;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_id_o !== '0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: valid/id/busy got %b/%0d/%b expected 0/0/0", rsp_valid_o, rsp_id_o, busy_o);
        end
        checks++;
        if (add_a_o !== '0 || add_b_o !== '0 || add_cin_o !== 1'b0) begin
            errors++; $display("FAIL reset_ops: a/b/cin got %h/%h/%b expected 0/0/0", add_a_o, add_b_o, add_cin_o);
        end
    endtask

    // Single directed operation; also checks the fixed response timing and value.
    task automatic test_single(input string name, input int k, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin,
                               input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        req_a_i[k*WIDTH +: WIDTH] = a;
        req_b_i[k*WIDTH +: WIDTH] = b;
        req_cin_i[k]              = cin;
        for (int i = 0; i < LATENCY + 3; i++) begin
            req_valid_i = (i == 0) ? NUM_REQ'(1 << k) : '0;
            #1;
            checks++;
            if (req_ready_o !== exp_ready()) begin
                errors++; $display("FAIL %s_ready: got %b expected %b", name, req_ready_o, exp_ready());
            end
            tick();
            checks++;
            if (rsp_valid_o !== (i == LATENCY) || busy_o !== model_busy()) begin
                errors++; $display("FAIL %s_valid: valid/busy got %b/%b expected %b/%b",
                                   name, rsp_valid_o, busy_o, (i == LATENCY), model_busy());
            end
            if (i == LATENCY) begin
                checks++;
                if (rsp_id_o !== ID_W'(k) || rsp_sum_o !== exp_sum || rsp_cout_o !== exp_cout) begin
                    errors++; $display("FAIL %s_rsp: id/sum/cout got %0d/%h/%b expected %0d/%h/%b",
                                       name, rsp_id_o, rsp_sum_o, rsp_cout_o, k, exp_sum, exp_cout);
                end
            end
        end
    endtask

    task automatic test_rotation();
        rst_i = 1'b1;
        req_valid_i = '0;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 8 + LATENCY + 2; i++) begin
            rand_ops();
            req_valid_i = (i < 8) ? 4'b1111 : 4'b0000;
            #1;
            checks++;
            if (req_ready_o !== ((i < 8) ? NUM_REQ'(1 << (i % NUM_REQ)) : 4'b0000)) begin
                errors++; $display("FAIL rotation_grant: cycle %0d got %b expected %b", i, req_ready_o, exp_ready());
            end
            tick();
            checks++;
            if (rsp_valid_o !== slot_v[cyc % RING] || busy_o !== model_busy()) begin
                errors++; $display("FAIL rotation_valid: valid/busy got %b/%b expected %b/%b",
                                   rsp_valid_o, busy_o, slot_v[cyc % RING], model_busy());
            end
            if (slot_v[cyc % RING]) begin
                checks++;
                if (rsp_id_o !== slot_id[cyc % RING] || {rsp_cout_o, rsp_sum_o} !== slot_res[cyc % RING]) begin
                    errors++; $display("FAIL rotation_rsp: id/res got %0d/%h expected %0d/%h",
                                       rsp_id_o, {rsp_cout_o, rsp_sum_o}, slot_id[cyc % RING], slot_res[cyc % RING]);
                end
            end
        end
    endtask

    task automatic test_pair();
        logic [NUM_REQ-1:0] exp_g [7] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        for (int i = 0; i < 7 + LATENCY + 2; i++) begin
            rand_ops();
            req_valid_i = (i < 4) ? 4'b1010 : (i < 7) ? 4'b1000 : 4'b0000;
            #1;
            checks++;
            if (req_ready_o !== ((i < 7) ? exp_g[i] : exp_ready())) begin
                errors++; $display("FAIL pair_grant: cycle %0d got %b expected %b", i, req_ready_o, exp_ready());
            end
            tick();
            checks++;
            if (rsp_valid_o !== slot_v[cyc % RING] || busy_o !== model_busy()) begin
                errors++; $display("FAIL pair_valid: valid/busy got %b/%b expected %b/%b",
                                   rsp_valid_o, busy_o, slot_v[cyc % RING], model_busy());
            end
            if (slot_v[cyc % RING]) begin
                checks++;
                if (rsp_id_o !== slot_id[cyc % RING] || {rsp_cout_o, rsp_sum_o} !== slot_res[cyc % RING]) begin
                    errors++; $display("FAIL pair_rsp: id/res got %0d/%h expected %0d/%h",
                                       rsp_id_o, {rsp_cout_o, rsp_sum_o}, slot_id[cyc % RING], slot_res[cyc % RING]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int i = 0; i < 18; i++) begin
            rand_ops();
            req_valid_i = (i < 3) ? 4'b0001 : (i == 4) ? 4'b1111 : (i == 11) ? 4'b0010 : 4'b0000;
            rst_i = (i == 4);
            #1;
            checks++;
            if (req_ready_o !== exp_ready()) begin
                errors++; $display("FAIL rstmid_ready: cycle %0d got %b expected %b", i, req_ready_o, exp_ready());
            end
            tick();
            rst_i = 1'b0;
            if (i >= 4 && rsp_valid_o === 1'b1) pulses++;
            if (i == 4) begin
                checks++;
                if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
                    errors++; $display("FAIL rstmid_flush: busy/valid got %b/%b expected 0/0", busy_o, rsp_valid_o);
                end
            end
            checks++;
            if (rsp_valid_o !== slot_v[cyc % RING] || busy_o !== model_busy()) begin
                errors++; $display("FAIL rstmid_valid: cycle %0d valid/busy got %b/%b expected %b/%b",
                                   i, rsp_valid_o, busy_o, slot_v[cyc % RING], model_busy());
            end
            if (slot_v[cyc % RING]) begin
                checks++;
                if (rsp_id_o !== slot_id[cyc % RING] || {rsp_cout_o, rsp_sum_o} !== slot_res[cyc % RING]) begin
                    errors++; $display("FAIL rstmid_rsp: id/res got %0d/%h expected %0d/%h",
                                       rsp_id_o, {rsp_cout_o, rsp_sum_o}, slot_id[cyc % RING], slot_res[cyc % RING]);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            req_valid_i = (i == 0) ? 4'b1000 : (i == 3) ? 4'b0010 : (i == 4) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (req_ready_o !== exp_ready()) begin
                errors++; $display("FAIL gaps_ready: cycle %0d got %b expected %b", i, req_ready_o, exp_ready());
            end
            tick();
            checks++;
            if (rsp_valid_o !== (i == 4 || i == 7 || i == 8) || busy_o !== model_busy()) begin
                errors++; $display("FAIL gaps_valid: cycle %0d valid/busy got %b/%b expected %b/%b",
                                   i, rsp_valid_o, busy_o, (i == 4 || i == 7 || i == 8), model_busy());
            end
            if (slot_v[cyc % RING]) begin
                checks++;
                if (rsp_id_o !== slot_id[cyc % RING] || {rsp_cout_o, rsp_sum_o} !== slot_res[cyc % RING]) begin
                    errors++; $display("FAIL gaps_rsp: id/res got %0d/%h expected %0d/%h",
                                       rsp_id_o, {rsp_cout_o, rsp_sum_o}, slot_id[cyc % RING], slot_res[cyc % RING]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            rand_ops();
            req_valid_i = (i < 70) ? NUM_REQ'($urandom_range(0, 15)) : 4'b0000;
            #1;
            checks++;
            if (req_ready_o !== exp_ready()) begin
                errors++; $display("FAIL random_ready: cycle %0d got %b expected %b", i, req_ready_o, exp_ready());
            end
            tick();
            checks++;
            if (rsp_valid_o !== slot_v[cyc % RING] || busy_o !== model_busy()) begin
                errors++; $display("FAIL random_valid: cycle %0d valid/busy got %b/%b expected %b/%b",
                                   i, rsp_valid_o, busy_o, slot_v[cyc % RING], model_busy());
            end
            if (slot_v[cyc % RING]) begin
                checks++;
                if (rsp_id_o !== slot_id[cyc % RING] || {rsp_cout_o, rsp_sum_o} !== slot_res[cyc % RING]) begin
                    errors++; $display("FAIL random_rsp: id/res got %0d/%h expected %0d/%h",
                                       rsp_id_o, {rsp_cout_o, rsp_sum_o}, slot_id[cyc % RING], slot_res[cyc % RING]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < RING; i++) slot_v[i] = 1'b0;
        rst_i = 1'b1;
        req_valid_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        req_cin_i = '0;
        test_reset();
        test_single("basic", 2, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0009, 1'b0);
        test_single("carry", 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        test_rotation();
        test_pair();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
